// File: rtl/serial_subtractor_n_bit.sv
// serial_subtractor_n_bit: bit-serial a - b - bin, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor_n_bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;
    logic             accept;
    logic             last_bit;

    // Single full-subtractor cell
    assign d       = a_sr[0] ^ b_sr[0] ^ br;
    assign br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == BUSY) && (cnt == LAST);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            br     <= bin;
        end else if (state == BUSY) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {d, res_sr[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
            br     <= br_next;
        end
    end

    // Outputs only change on the MSB cycle, so partial results stay hidden
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff <= '0;
            bout <= 1'b0;
        end else if (last_bit) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= br_next;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= br ^ br_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Testbench for serial_subtractor_n_bit at WIDTH=4: vector table, handshake,
// reset and exhaustive checks; ovf checked when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor_n_bit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf_s;

    int n_tests;
    int n_fail;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    serial_subtractor_n_bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Golden model independent of the bit-serial structure
    task automatic model(input int av, input int bv, input int bi,
                         output int d, output int bo, output int ov);
        int sa, sb, r;
        d  = (av - bv - bi) & 15;
        bo = (av < bv + bi) ? 1 : 0;
        sa = (av >= 8) ? av - 16 : av;
        sb = (bv >= 8) ? bv - 16 : bv;
        r  = sa - sb - bi;
        ov = (r < -8 || r > 7) ? 1 : 0;
    endtask

    // Issue one op; lat = edges from E0 to done (-1 on timeout)
    task automatic run_op(input logic [3:0] av, input logic [3:0] bv,
                          input logic bi, output int lat, output int pulse_ok);
        lat = -1;
        pulse_ok = 0;
        @(negedge clk);
        a = av;
        b = bv;
        bin = bi;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        bin = ~bi;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat >= 0) begin
            @(negedge clk);
            pulse_ok = (!done && !busy) ? 1 : 0;
        end
    endtask

    task automatic check_op(input string name, input int av, input int bv,
                            input int bi, input int lat, input int pulse_ok);
        int ed, eb, eo;
        model(av, bv, bi, ed, eb, eo);
        check({name, " diff"}, int'(diff), ed);
        check({name, " bout"}, int'(bout), eb);
`ifdef SERIAL_SUB_OVF_EN
        check({name, " ovf"}, int'(ovf_s), eo);
`endif
        check({name, " latency"}, lat, W);
        check({name, " pulse"}, pulse_ok, 1);
    endtask

    initial begin
        int lat, pok, dcnt, last_rise, pb;
        logic [3:0] acc_q[$];
        logic [3:0] exp_d;

        n_tests = 0;
        n_fail = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;

        vecs[0]  = '{4'd9,  4'd3,  1'b0, 4'd6,  1'b0, 1'b1};
        vecs[1]  = '{4'd3,  4'd9,  1'b0, 4'hA,  1'b1, 1'b1};
        vecs[2]  = '{4'd5,  4'd5,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[3]  = '{4'd8,  4'd1,  1'b0, 4'd7,  1'b0, 1'b1};
        vecs[4]  = '{4'd7,  4'd15, 1'b0, 4'd8,  1'b1, 1'b1};
        vecs[5]  = '{4'd6,  4'd2,  1'b0, 4'd4,  1'b0, 1'b0};
        vecs[6]  = '{4'd12, 4'd4,  1'b0, 4'd8,  1'b0, 1'b0};
        vecs[7]  = '{4'd0,  4'd0,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[8]  = '{4'd15, 4'd15, 1'b0, 4'd0,  1'b0, 1'b0};
        vecs[9]  = '{4'd0,  4'd15, 1'b0, 4'd1,  1'b1, 1'b0};
        vecs[10] = '{4'd8,  4'd8,  1'b1, 4'hF,  1'b1, 1'b0};
        vecs[11] = '{4'd7,  4'd8,  1'b0, 4'hF,  1'b1, 1'b1};

        #12;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset diff", int'(diff), 0);
        check("reset bout", int'(bout), 0);
        check("reset ovf", int'(ovf_s), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, pok);
            check($sformatf("vec%0d diff", i), int'(diff), int'(vecs[i].d));
            check($sformatf("vec%0d bout", i), int'(bout), int'(vecs[i].bo));
`ifdef SERIAL_SUB_OVF_EN
            check($sformatf("vec%0d ovf", i), int'(ovf_s), int'(vecs[i].ov));
`endif
            check($sformatf("vec%0d latency", i), lat, W);
            check($sformatf("vec%0d pulse", i), pok, 1);
        end

        // start held high, operands changing every cycle
        @(negedge clk);
        b = 4'd2;
        bin = 1'b0;
        start = 1'b1;
        a = 4'd5;
        last_rise = -1;
        pb = 0;
        dcnt = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy && pb == 0) begin
                acc_q.push_back(a);
                if (last_rise >= 0) check("b2b spacing", n - last_rise, W + 2);
                last_rise = n;
            end
            if (done) begin
                dcnt++;
                if (acc_q.size() > 0) begin
                    exp_d = acc_q.pop_front() - 4'd2;
                    check("b2b diff", int'(diff), int'(exp_d));
                end else begin
                    check("b2b done without accept", 1, 0);
                end
            end
            pb = busy ? 1 : 0;
            a = 4'((n * 3 + 7) & 15);
        end
        start = 1'b0;
        check("b2b done count", dcnt, 6);
        repeat (W + 3) @(negedge clk);

        // start pulses during BUSY and DONE must not spawn an extra op
        a = 4'd10;
        b = 4'd3;
        bin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            if (done) dcnt++;
            start = (k == 2 || k == W) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("ignored start done count", dcnt, 1);
        check("ignored start diff", int'(diff), 7);

        // Reset two cycles after the accepting edge
        a = 4'd1;
        b = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst busy", int'(busy), 0);
        check("midrst done", int'(done), 0);
        check("midrst diff", int'(diff), 0);
        check("midrst bout", int'(bout), 0);
        check("midrst ovf", int'(ovf_s), 0);
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("midrst quiet", dcnt, 0);
        rst_n = 1'b1;
        run_op(4'd12, 4'd4, 1'b0, lat, pok);
        check_op("post reset", 12, 4, 0, lat, pok);

        // Exhaustive sweep against the golden model
        for (int av = 0; av < 16; av++) begin
            for (int bv = 0; bv < 16; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    run_op(4'(av), 4'(bv), 1'(bi), lat, pok);
                    check_op($sformatf("exh %0d-%0d-%0d", av, bv, bi),
                             av, bv, bi, lat, pok);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_n_bit.md
# serial_subtractor_n_bit

Bit-serial N-bit subtractor, the inverse of the ripple-carry adder block. It computes a − b − bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. A start/done handshake wraps the operation so it can sit beside the parallel adder in the arithmetic datapath, wherever area matters more than latency.

## Interface
- WIDTH, default 4: operand and result width in bits; legal range is 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- bin  input  1  borrow-in; sampled on the accepting edge only.
- busy  output  1  high while state is BUSY or DONE.
- done  output  1  one-cycle pulse; diff and bout are valid from this cycle onward.
- diff  output  WIDTH  result, equal to (a − b − bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
- ovf  output  1  signed overflow; present only with SERIAL_SUB_OVF_EN.

## Operation
- The FSM has three states: IDLE, BUSY, DONE. Reset state is IDLE.
- **IDLE:**
  - If start=1, capture a and b into the shift registers, load the borrow flip-flop with bin, clear the bit counter, and go to BUSY.
  - If start=0, stay in IDLE.
- **BUSY:** each cycle processes bit i = counter.
  - d = a_sr[0] ^ b_sr[0] ^ br.
  - br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br).
  - d shifts into the MSB of the internal result register. a_sr and b_sr shift right.
  - The counter increments and is ceil(log2(WIDTH+1)) bits wide.
  - On the cycle that processes bit WIDTH−1, the full result goes to diff, br_next goes to bout, and the FSM moves to DONE.
- **DONE:** done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start is ignored in BUSY and DONE. It is not queued.
- diff and bout hold their last result until the next operation completes. Partial results never appear on the outputs.
- Changes on a, b, or bin after the accepting edge have no effect.
- All arithmetic is unsigned modulo 2^WIDTH. bin=1 subtracts one more LSB.

## Timing
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. All internal shift registers, the counter, and br are cleared.
- Let E0 be the edge that samples start=1 in IDLE.
  - busy rises after E0.
  - Edges E1..E_WIDTH process bits 0..WIDTH−1.
  - done, diff, bout (and ovf) update after E_WIDTH, so latency is WIDTH cycles from E0.
  - done falls and busy falls after E_WIDTH+1.
- The earliest next accepting edge is E_WIDTH+2, giving a throughput of one operation per WIDTH+2 cycles.
- If start is held high continuously, back-to-back operations run with exactly that period.
- If rst_n is asserted mid-operation, all state and outputs return to reset values immediately. The operation in progress is discarded and no done pulse is produced.
- Reset deassertion is synchronized externally. The first start is honoured on the first rising edge after rst_n goes high.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- **Defined:**
  - The ovf port exists.
  - On the MSB cycle, ovf = br ^ br_next, i.e. the borrow into the MSB XOR the borrow out of it.
  - ovf is registered alongside diff, held with it, and reset to 0.
- **Undefined:**
  - The ovf port and its logic are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4.
- **Basic subtract:** a=9, b=3, bin=0 → diff=6, bout=0. done pulses for exactly 1 cycle, 4 edges after E0.
- **Underflow:** a=3, b=9, bin=0 → diff=0xA, bout=1. With borrow-in: a=5, b=5, bin=1 → diff=0xF, bout=1.
- **Overflow (SERIAL_SUB_OVF_EN defined):**
  - a=8, b=1 → diff=7, bout=0, ovf=1.
  - a=7, b=15 → diff=8, bout=1, ovf=1.
  - a=6, b=2 → diff=4, ovf=0.
- **Handshake:**
  - start held high with a changing every cycle → results correspond only to the operands at the accepting edges.
  - Accepting edges are spaced exactly 6 cycles apart.
  - A start pulse in BUSY or DONE produces no extra done.
- **Reset mid-operation:**
  - Assert rst_n=0 two cycles after E0 → busy, done, diff, bout immediately 0.
  - After release, a new start with a=12, b=4 → diff=8.
- **Exhaustive:** all 16×16×2 combinations of a, b, bin, checked against a golden model of (a − b − bin) mod 16 and the expected borrow.
